// File: rtl/adder_sched_pkg.sv
// Shared types and widths for the adder access scheduler.
//   OPER_W : operand width of the external adder
//   SUM_W  : result width {cout, sum}
//   CNT_W  : settle counter width (holds 1..15)
//   state_t: scheduler FSM states
package adder_sched_pkg;

   localparam int unsigned OPER_W = 4;
   localparam int unsigned SUM_W  = 5;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RESP
   } state_t;

endpackage

// File: rtl/adder_access_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational.
//   req        : request vector, bit N = requester N valid
//   last_grant : requester served most recently
//   grant      : one-hot grant (all zero when nothing requests)
//   grant_id   : index of the granted requester
// A lone requester always wins; on a tie the one that was not served last wins.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant    = '0;
      grant_id = 1'b0;
      case (req)
         2'b01: begin
            grant    = 2'b01;
            grant_id = 1'b0;
         end
         2'b10: begin
            grant    = 2'b10;
            grant_id = 1'b1;
         end
         2'b11: begin
            if (last_grant) begin
               grant    = 2'b01;
               grant_id = 1'b0;
            end else begin
               grant    = 2'b10;
               grant_id = 1'b1;
            end
         end
         default: begin
            grant    = '0;
            grant_id = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/adder_access_scheduler.sv
// Shares one external 4-bit adder between two requesters.
//   clock, reset           : system clock, synchronous active-high reset
//   reqN_valid/a/b         : operand pair offered by requester N
//   reqN_ready             : pair from requester N accepted this cycle
//   add_a, add_b           : registered operands driven to the adder
//   add_sum, add_cout      : adder result inputs
//   rsp_valid/rsp_id/rsp_sum : one-cycle result pulse, owner and {cout,sum}
//   disp_value             : last captured result for the display path
//   busy                   : high whenever an operation is in flight
// Operands are held on the adder for SETTLE_CYCLES cycles before the result
// is captured; one operation completes every SETTLE_CYCLES+2 cycles.
module adder_access_scheduler
   import adder_sched_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [OPER_W-1:0] req0_a,
   input  logic [OPER_W-1:0] req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [OPER_W-1:0] req1_a,
   input  logic [OPER_W-1:0] req1_b,
   output logic              req1_ready,
   output logic [OPER_W-1:0] add_a,
   output logic [OPER_W-1:0] add_b,
   input  logic [OPER_W-1:0] add_sum,
   input  logic              add_cout,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [SUM_W-1:0]  rsp_sum,
   output logic [SUM_W-1:0]  disp_value,
   output logic              busy
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..15");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  cnt;
   logic              last_grant;
   logic              grant_id_q;
   logic [1:0]        grant;
   logic              arb_id;
   logic              xfer;
   logic              capture;

   rr_arbiter_2 u_arb (
      .req        ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_id   (arb_id)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next state, handshake and capture strobes
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      xfer       = 1'b0;
      capture    = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            // grant is only non-zero for a requester whose valid is high
            req0_ready = grant[0];
            req1_ready = grant[1];
            if (|grant) begin
               xfer       = 1'b1;
               next_state = SETTLE;
            end
         end
         SETTLE: begin
            // <= 1 rather than == 1 so a corrupted zero count cannot hang
            if (cnt <= CNT_W'(1)) begin
               capture    = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // ------------------------------------------------------------------
   // Operand, counter and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         add_a      <= '0;
         add_b      <= '0;
         cnt        <= '0;
         grant_id_q <= 1'b0;
         last_grant <= 1'b1;
         rsp_sum    <= '0;
         rsp_id     <= 1'b0;
         disp_value <= '0;
      end else begin
         if (xfer) begin
            add_a      <= arb_id ? req1_a : req0_a;
            add_b      <= arb_id ? req1_b : req0_b;
            grant_id_q <= arb_id;
            cnt        <= CNT_LOAD;
         end else if (state == SETTLE) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (capture) begin
            rsp_sum    <= {add_cout, add_sum};
            disp_value <= {add_cout, add_sum};
            rsp_id     <= grant_id_q;
            last_grant <= grant_id_q;
         end
      end
   end

endmodule

// File: tb/tb_adder_access_scheduler.sv
// Directed bench for adder_access_scheduler: one instance with SETTLE_CYCLES=1
// on an ideal combinational adder, one with SETTLE_CYCLES=3 on an adder
// whose result becomes correct only in the third cycle operands are held.
module tb_adder_access_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;

   // instance with SETTLE_CYCLES = 1
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       req0_ready, req1_ready;
   logic [3:0] add_a, add_b, add_sum;
   logic       add_cout;
   logic       rsp_valid, rsp_id, busy;
   logic [4:0] rsp_sum, disp_value;

   // instance with SETTLE_CYCLES = 3
   logic       d3_req0_valid = 1'b0, d3_req1_valid = 1'b0;
   logic [3:0] d3_req0_a = '0, d3_req0_b = '0, d3_req1_a = '0, d3_req1_b = '0;
   logic       d3_req0_ready, d3_req1_ready;
   logic [3:0] d3_add_a, d3_add_b, d3_add_sum;
   logic       d3_add_cout;
   logic       d3_rsp_valid, d3_rsp_id, d3_busy;
   logic [4:0] d3_rsp_sum, d3_disp_value;

   logic [4:0] lag1 = '0, lag2 = '0;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   always #5 clock = ~clock;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   always_ff @(posedge clock) begin
      lag1 <= {1'b0, d3_add_a} + {1'b0, d3_add_b};
      lag2 <= lag1;
   end
   assign {d3_add_cout, d3_add_sum} = lag2;

   adder_access_scheduler #(.SETTLE_CYCLES(1)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_sum    (add_sum),
      .add_cout   (add_cout),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .disp_value (disp_value),
      .busy       (busy)
   );

   adder_access_scheduler #(.SETTLE_CYCLES(3)) dut3 (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (d3_req0_valid),
      .req0_a     (d3_req0_a),
      .req0_b     (d3_req0_b),
      .req0_ready (d3_req0_ready),
      .req1_valid (d3_req1_valid),
      .req1_a     (d3_req1_a),
      .req1_b     (d3_req1_b),
      .req1_ready (d3_req1_ready),
      .add_a      (d3_add_a),
      .add_b      (d3_add_b),
      .add_sum    (d3_add_sum),
      .add_cout   (d3_add_cout),
      .rsp_valid  (d3_rsp_valid),
      .rsp_id     (d3_rsp_id),
      .rsp_sum    (d3_rsp_sum),
      .disp_value (d3_disp_value),
      .busy       (d3_busy)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      advance();
      advance();
      reset = 1'b0;
      sample();
      check("rst busy", busy, 0);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst add_a", add_a, 0);
      check("rst rsp_sum", rsp_sum, 0);
      check("rst disp", disp_value, 0);
      advance();
   endtask

   // one operation on the SETTLE_CYCLES=1 instance, from IDLE back to IDLE
   task automatic run_single(input logic id, input logic [3:0] a, input logic [3:0] b,
                             input int unsigned exp);
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end
      sample();
      check("single ready0", req0_ready, id ? 0 : 1);
      check("single ready1", req1_ready, id ? 1 : 0);
      check("single busy idle", busy, 0);
      advance();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      sample();
      check("single busy settle", busy, 1);
      check("single add_a", add_a, a);
      check("single add_b", add_b, b);
      check("single no rsp", rsp_valid, 0);
      check("single ready0 settle", req0_ready, 0);
      check("single ready1 settle", req1_ready, 0);
      advance();
      sample();
      check("single rsp_valid", rsp_valid, 1);
      check("single rsp_id", rsp_id, id);
      check("single rsp_sum", rsp_sum, exp);
      check("single disp", disp_value, exp);
      check("single ready0 resp", req0_ready, 0);
      check("single ready1 resp", req1_ready, 0);
      advance();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      advance();
      do_reset();

      // 1: basic op, 9+7
      run_single(1'b0, 4'd9, 4'd7, 16);
      sample();
      check("t1 rsp_valid low", rsp_valid, 0);
      check("t1 busy low", busy, 0);
      check("t1 disp held", disp_value, 16);
      advance();

      // 3: boundary operands, results hold between responses
      run_single(1'b0, 4'd15, 4'd15, 30);
      run_single(1'b0, 4'd0, 4'd0, 0);
      run_single(1'b0, 4'd8, 4'd8, 16);
      for (int i = 0; i < 2; i++) begin
         sample();
         check("t3 sum held", rsp_sum, 16);
         check("t3 add_a held", add_a, 8);
         advance();
      end

      // 2: both requesting continuously, grants alternate starting at 0
      do_reset();
      req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4;
      req1_valid = 1'b1; req1_a = 4'd8; req1_b = 4'd8;
      for (int k = 0; k < 12; k++) begin
         int unsigned g;
         g = (k / 3) % 2;
         sample();
         case (k % 3)
            0: begin
               check("t2 ready0", req0_ready, g == 0);
               check("t2 ready1", req1_ready, g == 1);
            end
            1: begin
               check("t2 add_a", add_a, g ? 8 : 3);
               check("t2 busy", busy, 1);
            end
            default: begin
               check("t2 rsp_valid", rsp_valid, 1);
               check("t2 rsp_id", rsp_id, g);
               check("t2 rsp_sum", rsp_sum, g ? 16 : 7);
            end
         endcase
         advance();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // 6: only req1, back-to-back
      do_reset();
      for (int n = 0; n < 3; n++) begin
         run_single(1'b1, 4'd5, 4'd6, 11);
      end

      // 5: reset during SETTLE of a req1 operation
      req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd13;
      sample();
      check("t5 ready1", req1_ready, 1);
      advance();
      req1_valid = 1'b0;
      sample();
      check("t5 busy settle", busy, 1);
      reset = 1'b1;
      advance();
      reset = 1'b0;
      sample();
      check("t5 rsp_valid", rsp_valid, 0);
      check("t5 busy", busy, 0);
      check("t5 add_a", add_a, 0);
      check("t5 add_b", add_b, 0);
      check("t5 rsp_sum", rsp_sum, 0);
      check("t5 rsp_id", rsp_id, 0);
      check("t5 disp", disp_value, 0);
      advance();
      sample();
      check("t5 still no rsp", rsp_valid, 0);
      advance();
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd5;
      req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
      sample();
      check("t5 tie ready0", req0_ready, 1);
      check("t5 tie ready1", req1_ready, 0);
      advance();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      advance();
      sample();
      check("t5 tie rsp_id", rsp_id, 0);
      check("t5 tie rsp_sum", rsp_sum, 7);
      advance();

      // 4: SETTLE_CYCLES=3 against a lagging adder
      for (int op = 0; op < 2; op++) begin
         logic [3:0] a;
         logic [3:0] b;
         a = (op == 0) ? 4'd9 : 4'd15;
         b = (op == 0) ? 4'd6 : 4'd15;
         d3_req0_valid = 1'b1; d3_req0_a = a; d3_req0_b = b;
         sample();
         check("t4 ready", d3_req0_ready, 1);
         check("t4 busy idle", d3_busy, 0);
         advance();
         d3_req0_valid = 1'b0;
         for (int c = 1; c <= 3; c++) begin
            sample();
            check("t4 busy settle", d3_busy, 1);
            check("t4 no rsp", d3_rsp_valid, 0);
            check("t4 add_a", d3_add_a, a);
            check("t4 add_b", d3_add_b, b);
            advance();
         end
         sample();
         check("t4 rsp_valid", d3_rsp_valid, 1);
         check("t4 busy resp", d3_busy, 1);
         check("t4 rsp_id", d3_rsp_id, 0);
         check("t4 rsp_sum", d3_rsp_sum, (op == 0) ? 15 : 30);
         advance();
         sample();
         check("t4 rsp_valid low", d3_rsp_valid, 0);
         check("t4 busy low", d3_busy, 0);
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
